// File: rtl/fir_decim_out.sv
// Output stage of the 21-tap FIR: runtime decimation, FWFT sample FIFO with
// valid/ready drain, and clip/peak/overflow health statistics.
module fir_decim_out #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int DECIM_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [7:0]       in_sample,
    input  logic                    in_valid,
    input  logic [DECIM_W-1:0]      decim,
    output logic signed [7:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AW:0]             fifo_level,
    output logic                    overflow,
    output logic [15:0]             clip_count,
    output logic [7:0]              peak_abs,
    input  logic                    clear
);

    logic [DECIM_W-1:0]   r_phase;
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic signed [7:0]    r_mem [DEPTH];
    logic                 r_overflow;
    logic [15:0]          r_clip;
    logic [7:0]           r_peak;

    logic [DECIM_W-1:0]   w_deff_m1;
    logic                 w_keep;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_clip;
    logic [8:0]           w_abs9;

    always_comb begin
        w_deff_m1 = (decim == '0) ? '0 : decim - DECIM_W'(1);
        w_keep    = in_valid && (r_phase == '0);
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop     = !w_empty && out_ready;
        // a pop in the same cycle frees the slot for a write into a full FIFO
        w_push    = w_keep && (!w_full || w_pop);
        w_drop    = w_keep && w_full && !w_pop;
        w_clip    = (in_sample == 8'sh7F) || (in_sample == 8'sh80);
        w_abs9    = in_sample[7] ? (9'd0 - {1'b1, in_sample}) : {1'b0, in_sample};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (in_valid) begin
            if (r_phase >= w_deff_m1) r_phase <= '0;
            else                      r_phase <= r_phase + DECIM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // When full with a pop, the write slot equals the head being popped;
    // the head is read combinationally before the write lands.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_sample;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_overflow <= 1'b0;
            r_clip     <= '0;
            r_peak     <= '0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (in_valid) begin
                if (w_clip && r_clip != 16'hFFFF) r_clip <= r_clip + 16'd1;
                if (w_abs9 > {1'b0, r_peak})     r_peak <= w_abs9[7:0];
            end
        end
    end

    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? 8'sd0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;
    assign clip_count = r_clip;
    assign peak_abs   = r_peak;

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fir_decim_out;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [7:0] in_sample = '0;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     decim = 4'd1;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [AW:0]       fifo_level;
    logic              overflow;
    logic [15:0]       clip_count;
    logic [7:0]        peak_abs;
    logic              clear = 1'b0;

    fir_decim_out #(.DEPTH(DEPTH), .AW(AW), .DECIM_W(DW)) dut (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
        .decim(decim), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow),
        .clip_count(clip_count), .peak_abs(peak_abs), .clear(clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: queue FIFO, integer phase and statistics
    int m_q[$];
    int m_phase = 0;
    int m_ovf = 0;
    int m_clip = 0;
    int m_peak = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_ovf = 0; m_clip = 0; m_peak = 0;
        end else begin
            int deff, s, a;
            bit pop, keep, dropped;
            deff    = (decim == 0) ? 1 : int'(decim);
            s       = int'(in_sample);
            pop     = (m_q.size() > 0) && out_ready;
            keep    = in_valid && (m_phase == 0);
            dropped = 1'b0;
            if (in_valid) m_phase = (m_phase >= deff - 1) ? 0 : m_phase + 1;
            if (pop) void'(m_q.pop_front());
            if (keep) begin
                if (m_q.size() < DEPTH) m_q.push_back(s);
                else dropped = 1'b1;
            end
            if (clear) begin
                m_ovf = 0; m_clip = 0; m_peak = 0;
            end else begin
                if (dropped) m_ovf = 1;
                if (in_valid) begin
                    a = (s < 0) ? -s : s;
                    if ((s == 127 || s == -128) && m_clip < 65535) m_clip++;
                    if (a > m_peak) m_peak = a;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("out_valid", int'(out_valid), (m_q.size() > 0) ? 1 : 0);
            if (m_q.size() > 0) chk("out_data", int'(out_data), m_q[0]);
            chk("fifo_level", int'(fifo_level), m_q.size());
            chk("overflow", int'(overflow), m_ovf);
            chk("clip_count", int'(clip_count), m_clip);
            chk("peak_abs", int'(peak_abs), m_peak);
        end
    end

    // accepted-output log for literal sequence checks
    int got[$];
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(int'(out_data));
    end

    int exp_q[$];
    task automatic chk_seq(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(name, got[i], exp_q[i]);
    endtask

    task automatic cyc(input bit v, input logic signed [7:0] s, input bit rdy, input bit clr);
        in_valid  = v;
        in_sample = s;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #2;
        en = 1'b1;

        // reset with in_valid asserted: nothing is written
        rst = 1'b1;
        cyc(1, 55, 0, 0);
        cyc(1, 56, 1, 0);
        rst = 1'b0;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_clip", int'(clip_count), 0);
        cyc(0, 0, 0, 0);
        chk("rst_idle_valid", int'(out_valid), 0);

        // decimate by 3
        do_rst();
        decim = 4'd3;
        got.delete();
        cyc(1, 1, 1, 0);
        chk("d3_lat_valid", int'(out_valid), 1);
        chk("d3_lat_data", int'(out_data), 1);
        for (int i = 2; i <= 9; i++) cyc(1, 8'(i), 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        exp_q = {1, 4, 7};
        chk_seq("d3_seq");

        // decim=0 behaves as 1
        do_rst();
        decim = 4'd0;
        got.delete();
        for (int i = 5; i <= 7; i++) cyc(1, 8'(i), 1, 0);
        cyc(0, 0, 1, 0);
        exp_q = {5, 6, 7};
        chk_seq("d0_seq");

        // overflow, then clear concurrent with a dropped write
        do_rst();
        decim = 4'd1;
        for (int i = 10; i <= 19; i++) cyc(1, 8'(i), 0, 0);
        cyc(0, 0, 0, 0);
        chk("ovf_level", int'(fifo_level), 8);
        chk("ovf_flag", int'(overflow), 1);
        cyc(1, 99, 0, 1);
        chk("ovf_clear_drop", int'(overflow), 0);
        got.delete();
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0);
        exp_q = {10, 11, 12, 13, 14, 15, 16, 17};
        chk_seq("ovf_drain");

        // full plus simultaneous pop
        do_rst();
        for (int i = 30; i <= 37; i++) cyc(1, 8'(i), 0, 0);
        got.delete();
        cyc(1, 20, 1, 0);
        chk("fullpop_level", int'(fifo_level), 8);
        chk("fullpop_ovf", int'(overflow), 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0);
        exp_q = {30, 31, 32, 33, 34, 35, 36, 37, 20};
        chk_seq("fullpop_seq");

        // statistics
        do_rst();
        cyc(1, 127, 1, 0);
        cyc(1, -128, 1, 0);
        cyc(1, -5, 1, 0);
        cyc(1, 100, 1, 0);
        cyc(1, 127, 1, 0);
        chk("st_clip", int'(clip_count), 3);
        chk("st_peak", int'(peak_abs), 128);
        cyc(1, -128, 1, 1);
        chk("st_clr_clip", int'(clip_count), 0);
        chk("st_clr_peak", int'(peak_abs), 0);
        cyc(1, -5, 1, 0);
        chk("st_peak5", int'(peak_abs), 5);

        // clip counter saturation
        do_rst();
        for (int i = 0; i < 65537; i++) cyc(1, 127, 1, 0);
        chk("st_sat", int'(clip_count), 65535);

        // randomized traffic
        do_rst();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) decim = DW'($urandom_range(0, 5));
            rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 49) == 0);
        end
        rst = 1'b0;
        cyc(0, 0, 1, 0);

        en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Downstream stage of the 8-bit signed 21-tap low-pass FIR.
- Consumes the filtered sample stream as sample plus strobe, keeps one sample in every D (runtime decimation factor), and buffers kept samples in a first-word-fall-through FIFO.
- The FIFO drains over a valid/ready handshake.
- Also tracks filter-output health: clip count, peak magnitude and a sticky FIFO-overflow flag, for the FIR overflow monitor.

Parameters:
- DEPTH, 8, FIFO entries. Must be a power of 2, at least 2.
- AW, 3, log2(DEPTH).
- DECIM_W, 4, width of decim input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_sample  in  8  signed filtered sample from FIR.
- in_valid  in  1  one-cycle strobe; in_sample is valid this cycle.
- decim  in  DECIM_W  decimation factor D; 0 is treated as 1.
- out_data  out  8  signed FIFO head sample.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- fifo_level  out  AW+1  entries held, 0..DEPTH.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.
- clip_count  out  16  count of in_valid samples equal to +127 or -128; saturates at 0xFFFF.
- peak_abs  out  8  unsigned max |in_sample| seen; |-128| = 128.
- clear  in  1  sync clear of overflow, clip_count and peak_abs only.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, fifo_level=0, overflow=0, clip_count=0, peak_abs=0, out_data=0.
  - Phase counter=0; FIFO pointers=0.
  - rst overrides all other inputs in the same cycle.
- Decimation phase counter:
  - Advances only on in_valid.
  - A sample is kept when phase==0 at its in_valid.
  - Phase increments; it wraps to 0 when phase >= Deff-1, where Deff = max(decim, 1).
  - D=1 keeps every sample.
  - decim may change at any time. The new value is used at the next in_valid comparison. If the current phase >= new Deff-1, the next in_valid wraps the phase to 0 (that sample is not kept unless phase is already 0).
- FIFO write:
  - The write request is a kept sample.
  - If not full, the sample is written and appears on out_data with out_valid=1 on the cycle after the in_valid (1-cycle latency from an empty FIFO).
  - If full and a pop occurs the same cycle, the write is accepted and the level is unchanged.
  - If full and no pop, the sample is dropped and overflow is set to 1 the next cycle.
- FIFO read:
  - Pop when out_valid && out_ready.
  - out_data is always the oldest entry, first-word fall-through.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - out_ready while empty has no effect.
  - Simultaneous push and pop on an empty FIFO: no pop (out_valid was 0); the push lands and the level becomes 1.
- Pointers: AW+1-bit, wrap naturally.
  - full = MSBs differ and lower bits are equal.
  - fifo_level = wr_ptr - rd_ptr.
- Statistics, updated on every in_valid (kept or not):
  - clip_count increments when in_sample == 8'sh7F or 8'sh80; it holds at 0xFFFF.
  - peak_abs = max(peak_abs, |in_sample|), computed in 9-bit unsigned; the result always fits in 8 bits.
- clear:
  - Next cycle: overflow=0, clip_count=0, peak_abs=0.
  - clear with in_valid in the same cycle: clear wins and that sample's statistics are discarded. Decimation and FIFO still process the sample normally.
  - clear with a dropped write in the same cycle: overflow ends 0.
- No combinational path from in_valid or in_sample to outputs. out_valid and out_data depend only on registered state.

Test Plan:
- Reset/idle: assert rst 2 cycles → all outputs 0, fifo_level=0. in_valid with rst=1 → nothing written.
- Decimate by 3: decim=3, out_ready=1, feed samples 1..9 on consecutive in_valid → out_data sequence 1,4,7, each out_valid exactly 1 cycle after its in_valid.
- decim=0 vs 1: feed 5,6,7 with decim=0 → output 5,6,7, identical to decim=1.
- Overflow: DEPTH=8, decim=1, out_ready=0, push 10 samples 10..19 → fifo_level=8, overflow=1. Then out_ready=1 drains 10..17 in order; 18 and 19 are lost.
- Full plus simultaneous pop: fill to 8, then in_valid=20 while out_ready=1 → level stays 8, no overflow, 20 is last out.
- Statistics: feed 127, -128, -5, 100, 127 → clip_count=3, peak_abs=128. clear together with a -128 sample → clip_count=0, peak_abs=0. 65536 clips → clip_count=0xFFFF.
